// File: rtl/tmec_chien_search.sv
// Serial Chien search: evaluates the error-locator sigma(x) at alpha^(S+k), one position per handshake.
// Define TMEC_CHIEN_FAIL_DETECT_EN to build the degree check, root counter, err_count and fail outputs.
module tmec_chien_search #(
    parameter int M = 32'sd4,
    parameter int T = 32'sd3,
    parameter int S = 32'sd0,
    parameter int L = (32'sd1 << M) - 32'sd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [M*(T+1)-1:0]     sigma,
    output logic                   busy,
    output logic                   err_valid,
    input  logic                   err_ready,
    output logic                   err,
    output logic                   err_last,
    output logic                   done,
    output logic [$clog2(T+2)-1:0] err_count,
    output logic                   fail
);
    localparam int N  = (32'sd1 << M) - 32'sd1;
    localparam int KW = (L > 32'sd1) ? $clog2(L) : 32'sd1;
    localparam int CW = $clog2(T + 32'sd2);
    localparam logic [KW-1:0] K_LAST   = KW'(L - 32'sd1);
    localparam logic [KW-1:0] K_PENULT = KW'((L > 32'sd1) ? (L - 32'sd2) : 32'sd0);
    localparam logic [KW-1:0] K_ONE    = KW'(32'sd1);

    function automatic logic [M-1:0] prim_low();
        logic [31:0] p;
        case (M)
            32'sd2:  p = 32'h0000_0003;
            32'sd3:  p = 32'h0000_0003;
            32'sd4:  p = 32'h0000_0003;
            32'sd5:  p = 32'h0000_0005;
            32'sd6:  p = 32'h0000_0003;
            32'sd7:  p = 32'h0000_0009;
            32'sd8:  p = 32'h0000_001D;
            32'sd9:  p = 32'h0000_0011;
            32'sd10: p = 32'h0000_0009;
            default: p = 32'h0000_0003;
        endcase
        return p[M-1:0];
    endfunction

    localparam logic [M-1:0] PRIM = prim_low();

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = {M{1'b0}};
        sh  = a;
        for (int j = 0; j < M; j++) begin
            if (b[j]) acc = acc ^ sh;
            sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ PRIM) : {sh[M-2:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] gf_alpha_pow(input int e);
        logic [M-1:0] r;
        logic [M-1:0] a;
        r    = {M{1'b0}};
        r[0] = 1'b1;
        a    = {M{1'b0}};
        a[1] = 1'b1;
        for (int j = 0; j < (e % N); j++) begin
            r = gf_mul(r, a);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           load_s;
    logic           hs_s;
    logic           last_hs_s;
    logic [KW-1:0]  k_r;
    logic           busy_r;
    logic           err_valid_r;
    logic           err_r;
    logic           err_last_r;
    logic           done_r;
    logic [M-1:0]   sigma0_r;
    logic           degen_r;
    logic [M-1:0]   coef_r     [1:T];
    logic [M-1:0]   load_val_s [1:T];
    logic [M-1:0]   step_val_s [1:T];
    logic [M-1:0]   acc_cur_s;
    logic [M-1:0]   acc_step_s;
    logic           root_cur_s;
    logic           root_step_s;

    // Constant multipliers: shortening offset at load, alpha^i per evaluated position.
    genvar gi;
    generate
        for (gi = 1; gi <= T; gi++) begin : g_coef
            localparam logic [M-1:0] LOAD_K = gf_alpha_pow(gi * S);
            localparam logic [M-1:0] STEP_K = gf_alpha_pow(gi);
            assign load_val_s[gi] = gf_mul(sigma[gi*M +: M], LOAD_K);
            assign step_val_s[gi] = gf_mul(coef_r[gi], STEP_K);
        end
    endgenerate

    // Evaluate sigma at the current and at the next position so err can be registered.
    always_comb begin
        acc_cur_s  = sigma0_r;
        acc_step_s = sigma0_r;
        for (int i = 1; i <= T; i++) begin
            acc_cur_s  = acc_cur_s ^ coef_r[i];
            acc_step_s = acc_step_s ^ step_val_s[i];
        end
    end

    // A zero sigma_0 is degenerate and flags every position.
    assign root_cur_s  = degen_r | (acc_cur_s == {M{1'b0}});
    assign root_step_s = degen_r | (acc_step_s == {M{1'b0}});

    // Next-state and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        hs_s        = 1'b0;
        last_hs_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (err_valid_r && err_ready) begin
                    hs_s = 1'b1;
                    if (k_r == K_LAST) begin
                        last_hs_s   = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Coefficient registers: loaded on start, stepped by alpha^i on each accepted flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sigma0_r <= {M{1'b0}};
            degen_r  <= 1'b0;
            for (int i = 1; i <= T; i++) coef_r[i] <= {M{1'b0}};
        end else if (load_s) begin
            sigma0_r <= sigma[M-1:0];
            degen_r  <= (sigma[M-1:0] == {M{1'b0}});
            for (int i = 1; i <= T; i++) coef_r[i] <= load_val_s[i];
        end else if (hs_s) begin
            for (int i = 1; i <= T; i++) coef_r[i] <= step_val_s[i];
        end
    end

    // State register, position counter and registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            k_r         <= {KW{1'b0}};
            busy_r      <= 1'b0;
            err_valid_r <= 1'b0;
            err_r       <= 1'b0;
            err_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= last_hs_s;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        busy_r <= 1'b1;
                        k_r    <= {KW{1'b0}};
                    end
                end
                ST_LOAD: begin
                    err_valid_r <= 1'b1;
                    err_r       <= root_cur_s;
                    err_last_r  <= (k_r == K_LAST);
                end
                ST_RUN: begin
                    if (last_hs_s) begin
                        err_valid_r <= 1'b0;
                        err_r       <= 1'b0;
                        err_last_r  <= 1'b0;
                    end else if (hs_s) begin
                        k_r        <= k_r + K_ONE;
                        err_r      <= root_step_s;
                        err_last_r <= (k_r == K_PENULT);
                    end
                end
                ST_DONE: busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign busy      = busy_r;
    assign err_valid = err_valid_r;
    assign err       = err_r;
    assign err_last  = err_last_r;
    assign done      = done_r;

`ifdef TMEC_CHIEN_FAIL_DETECT_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(T + 32'sd1);

    function automatic logic [CW-1:0] poly_degree(input logic [M*(T+1)-1:0] p);
        logic [CW-1:0] d;
        d = {CW{1'b0}};
        for (int i = 1; i <= T; i++) begin
            if (p[i*M +: M] != {M{1'b0}}) d = CW'(i);
        end
        return d;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] deg_r;
    logic [CW-1:0] cnt_inc_s;
    logic          fail_r;

    assign cnt_inc_s = (err_r && (cnt_r != CNT_MAX)) ? (cnt_r + CW'(32'sd1)) : cnt_r;

    // Root counter and degree comparison; results hold until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            deg_r  <= {CW{1'b0}};
            fail_r <= 1'b0;
        end else if (load_s) begin
            cnt_r  <= {CW{1'b0}};
            deg_r  <= poly_degree(sigma);
            fail_r <= 1'b0;
        end else if (hs_s) begin
            cnt_r <= cnt_inc_s;
            if (last_hs_s) fail_r <= degen_r | (cnt_inc_s != deg_r);
        end
    end

    assign err_count = cnt_r;
    assign fail      = fail_r;
`else
    assign err_count = {CW{1'b0}};
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_tmec_chien_search.sv
// Directed bench for tmec_chien_search over GF(16), T=3: full-length and L=11 instances.
module tb_tmec_chien_search;
`ifdef TMEC_CHIEN_FAIL_DETECT_EN
    localparam bit FD = 1'b1;
`else
    localparam bit FD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_sh;
    logic [15:0] sigma;
    logic        err_ready;
    logic        busy, err_valid, err, err_last, done, fail;
    logic [2:0]  err_count;
    logic        s_busy, s_err_valid, s_err, s_err_last, s_done, s_fail;
    logic [2:0]  s_err_count;
    int          checks;
    int          failures;

    tmec_chien_search #(.M(4), .T(3), .S(0), .L(15)) dut (
        .clk(clk), .reset(reset), .start(start), .sigma(sigma), .busy(busy),
        .err_valid(err_valid), .err_ready(err_ready), .err(err), .err_last(err_last),
        .done(done), .err_count(err_count), .fail(fail)
    );

    tmec_chien_search #(.M(4), .T(3), .S(0), .L(11)) dut_short (
        .clk(clk), .reset(reset), .start(start_sh), .sigma(sigma), .busy(s_busy),
        .err_valid(s_err_valid), .err_ready(err_ready), .err(s_err), .err_last(s_err_last),
        .done(s_done), .err_count(s_err_count), .fail(s_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one codeword and records what the consumer observes; no checking here.
    task automatic run_cw(input logic [15:0] sig, input bit sh, input int stall_a, input int stall_b,
                          input int pulse_k, input bit pulse_done,
                          output logic [14:0] flags, output logic [14:0] lasts, output int nhs,
                          output int done_cyc, output int busy_cyc, output logic [3:0] cf,
                          output int hold_err, output bit timeout, output logic [1:0] after_bd);
        int  cyc, stall_left;
        bit  fin, used_a, used_b, pulsed, prev_stall, prev_err, prev_last, seen_done;
        logic v, e, la, d, b;
        flags = 15'd0; lasts = 15'd0; nhs = 0; done_cyc = -1; busy_cyc = 0; cf = 4'd0;
        hold_err = 0; timeout = 1'b0; after_bd = 2'b11;
        cyc = 0; stall_left = 0; fin = 1'b0; used_a = 1'b0; used_b = 1'b0; pulsed = 1'b0;
        prev_stall = 1'b0; prev_err = 1'b0; prev_last = 1'b0; seen_done = 1'b0;
        sigma = sig;
        err_ready = 1'b1;
        if (sh) start_sh = 1'b1; else start = 1'b1;
        @(negedge clk);
        while (!fin) begin
            cyc++;
            start = 1'b0; start_sh = 1'b0; sigma = sig; err_ready = 1'b1;
            v  = sh ? s_err_valid : err_valid;
            e  = sh ? s_err : err;
            la = sh ? s_err_last : err_last;
            d  = sh ? s_done : done;
            b  = sh ? s_busy : busy;
            if (prev_stall && (!v || e !== prev_err || la !== prev_last)) hold_err++;
            prev_stall = 1'b0;
            if (seen_done) begin
                after_bd = {b, d};
                fin = 1'b1;
            end else begin
                if (b) busy_cyc++;
                if (v) begin
                    if (d) hold_err++;
                    if (nhs == stall_a && !used_a) begin used_a = 1'b1; stall_left = 3; end
                    if (nhs == stall_b && !used_b) begin used_b = 1'b1; stall_left = 3; end
                    if (nhs == pulse_k && !pulsed) begin
                        pulsed = 1'b1; sigma = 16'h0000;
                        if (sh) start_sh = 1'b1; else start = 1'b1;
                    end
                    if (stall_left > 0) begin
                        err_ready = 1'b0; stall_left--;
                        prev_stall = 1'b1; prev_err = e; prev_last = la;
                    end else begin
                        if (nhs < 15) begin flags[nhs] = e; lasts[nhs] = la; end
                        nhs++;
                    end
                end
                if (d) begin
                    seen_done = 1'b1; done_cyc = cyc;
                    cf = sh ? {s_err_count, s_fail} : {err_count, fail};
                    if (pulse_done) begin
                        sigma = 16'h0000;
                        if (sh) start_sh = 1'b1; else start = 1'b1;
                    end
                end
            end
            if (cyc >= 100) begin timeout = 1'b1; fin = 1'b1; end
            if (!fin) @(negedge clk);
        end
        start = 1'b0; start_sh = 1'b0; err_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, err_valid, err, err_last, done, err_count, fail} !== 9'd0) begin
            failures++;
            $display("FAIL reset_main got=%b want=%b", {busy, err_valid, err, err_last, done, err_count, fail}, 9'd0);
        end
        checks++;
        if ({s_busy, s_err_valid, s_err, s_err_last, s_done, s_err_count, s_fail} !== 9'd0) begin
            failures++;
            $display("FAIL reset_short got=%b want=%b",
                     {s_busy, s_err_valid, s_err, s_err_last, s_done, s_err_count, s_fail}, 9'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_no_errors();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0001, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h0000 || n !== 15) begin
            failures++; $display("FAIL noerr_flags got=%h n=%0d to=%0b want=0000 n=15", f, n, to);
        end
        checks++;
        if (la !== 15'h4000) begin failures++; $display("FAIL noerr_last got=%h want=4000", la); end
        checks++;
        if (dc !== 17 || bc !== 17 || ab !== 2'b00) begin
            failures++; $display("FAIL noerr_timing done=%0d busy=%0d after=%b want 17 17 00", dc, bc, ab);
        end
        checks++;
        if (cf !== 4'b0000) begin failures++; $display("FAIL noerr_count got=%b want=0000", cf); end
    endtask

    task automatic test_single();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0081, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h1000) begin failures++; $display("FAIL single_flags got=%h want=1000", f); end
        checks++;
        if (cf !== (FD ? 4'b0010 : 4'b0000)) begin
            failures++; $display("FAIL single_count got=%b want=%b", cf, (FD ? 4'b0010 : 4'b0000));
        end
    endtask

    task automatic test_double();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0B21, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h2400) begin failures++; $display("FAIL double_flags got=%h want=2400", f); end
        checks++;
        if (cf !== (FD ? 4'b0100 : 4'b0000)) begin
            failures++; $display("FAIL double_count got=%b want=%b", cf, (FD ? 4'b0100 : 4'b0000));
        end
    endtask

    task automatic test_shortened();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0B21, 1'b1, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h0400 || n !== 11) begin
            failures++; $display("FAIL short_flags got=%h n=%0d want=0400 n=11", f, n);
        end
        checks++;
        if (la !== 15'h0400) begin failures++; $display("FAIL short_last got=%h want=0400", la); end
        checks++;
        if (dc !== 13 || bc !== 13) begin
            failures++; $display("FAIL short_timing done=%0d busy=%0d want 13 13", dc, bc);
        end
        checks++;
        if (cf !== (FD ? 4'b0011 : 4'b0000)) begin
            failures++; $display("FAIL short_count got=%b want=%b", cf, (FD ? 4'b0011 : 4'b0000));
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0B21, 1'b0, 5, 10, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h2400 || n !== 15) begin
            failures++; $display("FAIL bp_flags got=%h n=%0d want=2400 n=15", f, n);
        end
        checks++;
        if (he !== 0) begin failures++; $display("FAIL bp_hold unstable=%0d want=0", he); end
        checks++;
        if (dc !== 23 || bc !== 23) begin
            failures++; $display("FAIL bp_timing done=%0d busy=%0d want 23 23", dc, bc);
        end
    endtask

    task automatic test_degenerate();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0000, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h7FFF) begin failures++; $display("FAIL degen_flags got=%h want=7fff", f); end
        checks++;
        if (cf !== (FD ? 4'b1001 : 4'b0000)) begin
            failures++; $display("FAIL degen_count got=%b want=%b", cf, (FD ? 4'b1001 : 4'b0000));
        end
    endtask

    task automatic test_start_ignored();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0B21, 1'b0, -1, -1, 4, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h2400 || dc !== 17) begin
            failures++; $display("FAIL midstart flags=%h done=%0d want=2400 17", f, dc);
        end
        checks++;
        if (cf !== (FD ? 4'b0100 : 4'b0000)) begin
            failures++; $display("FAIL midstart_count got=%b want=%b", cf, (FD ? 4'b0100 : 4'b0000));
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        run_cw(16'h0B21, 1'b0, -1, -1, -1, 1'b1, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || ab !== 2'b00 || bc !== 17) begin
            failures++; $display("FAIL donestart after=%b busy=%0d want 00 17", ab, bc);
        end
        run_cw(16'h0081, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h1000 || dc !== 17) begin
            failures++; $display("FAIL b2b flags=%h done=%0d want=1000 17", f, dc);
        end
    endtask

    task automatic test_reset_midrun();
        logic [14:0] f, la; int n, dc, bc, he; logic [3:0] cf; bit to; logic [1:0] ab;
        int seen;
        bit reached;
        seen = 0; reached = 1'b0;
        sigma = 16'h0B21; err_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clk);
            if (err_valid) begin
                if (seen == 7) reached = 1'b1;
                else seen++;
            end
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL rst_reach k=%0d want=7", seen); end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, err_valid, err, err_last, done, err_count, fail} !== 9'd0) begin
            failures++;
            $display("FAIL rst_async got=%b want=%b", {busy, err_valid, err, err_last, done, err_count, fail}, 9'd0);
        end
        @(negedge clk);
        checks++;
        if ({busy, err_valid, err, err_last, done, err_count, fail} !== 9'd0) begin
            failures++;
            $display("FAIL rst_hold got=%b want=%b", {busy, err_valid, err, err_last, done, err_count, fail}, 9'd0);
        end
        reset = 1'b0;
        run_cw(16'h0081, 1'b0, -1, -1, -1, 1'b0, f, la, n, dc, bc, cf, he, to, ab);
        checks++;
        if (to || f !== 15'h1000 || n !== 15 || dc !== 17) begin
            failures++; $display("FAIL rst_restart flags=%h n=%0d done=%0d want=1000 15 17", f, n, dc);
        end
        checks++;
        if (cf !== (FD ? 4'b0010 : 4'b0000)) begin
            failures++; $display("FAIL rst_count got=%b want=%b", cf, (FD ? 4'b0010 : 4'b0000));
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; start_sh = 1'b0; sigma = 16'h0001; err_ready = 1'b1;
        test_reset();
        test_no_errors();
        test_single();
        test_double();
        test_shortened();
        test_backpressure();
        test_degenerate();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tmec_chien_search.md
# tmec_chien_search

Serial Chien search stage that consumes the error-locator polynomial produced by the parallel inversionless Berlekamp-Massey decoder. It evaluates sigma(x) at successive field elements α^(S+k), emits one error flag per codeword position through a valid/ready stream, and reports the root count and decoding failure at the end of each codeword. It sits between the key-equation solver and the codeword correction XOR stage.

## Interface
- M, default 4: GF(2^M) field size; field arithmetic uses the shared BCH header functions and primitive polynomial.
- T, default 3: correctable errors; sigma has T+1 coefficients.
- S, default 0: start exponent; nonzero values support shortened codes.
- L, default 2^M-1: number of positions evaluated per codeword, 1 ≤ L ≤ 2^M-1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load request; accepted only when busy=0.
- sigma  in  M*(T+1)  locator coefficients; sigma_0 is in bits [M-1:0], sigma_i is in bits [i*M+:M].
- busy  out  1  high from the load through the done cycle.
- err_valid  out  1  err holds a valid flag for the current position.
- err_ready  in  1  consumer accepts the flag.
- err  out  1  1 when sigma(α^(S+k))=0 for the current position k.
- err_last  out  1  marks k=L-1; qualified by err_valid.
- done  out  1  single-cycle pulse after the last flag is accepted.
- err_count  out  clog2(T+2)  number of roots found; saturates at T+1.
- fail  out  1  root count differs from the sigma degree; qualified by done.

## Operation
- Reset, whether idle or mid-codeword, clears every output to 0 and clears all internal state: busy, err_valid, err, err_last, done, err_count, fail, the position counter k and the coefficient registers.
- **IDLE:**
  - On start=1, load reg_i = sigma_i·α^(i·S) for i=1..T, computed by constant multipliers at load.
  - Latch sigma_0 separately.
  - Compute the degree d, the index of the highest nonzero coefficient (d=0 if only sigma_0 is nonzero).
  - Clear k and the root count. Enter RUN and set busy=1.
- **RUN:**
  - err = (sigma_0 ^ reg_1 ^ … ^ reg_T) == 0.
  - err_valid=1. err_last = (k==L-1).
  - On a handshake (err_valid & err_ready):
    - each reg_i ← reg_i·α^i;
    - k ← k+1;
    - the root count increments if err=1, saturating at T+1.
  - Without a handshake, all registers hold and the outputs stay stable.
  - When the handshake occurs with k==L-1, enter DONE.
- **DONE:** one cycle long.
  - done=1, err_valid=0, and err_count and fail are valid.
  - Next state is IDLE and busy falls.
  - err_count holds its value until the next load.
- Handling of start:
  - start while busy=1 is ignored, with no effect on state.
  - start in the DONE cycle is ignored.
  - start in the cycle after DONE is accepted.
- An all-zero sigma (sigma_0=0) is treated as degenerate: every position flags err=1, the count saturates, and fail=1.

## Timing
- Load latency: start accepted at edge n, so err_valid=1 with k=0 after edge n+1.
- Throughput: one position per cycle while err_ready=1. A codeword occupies L+2 cycles from start to busy falling, including the load and DONE cycles.
- Output mapping: flag k refers to codeword bit (2^M-1-S-k) mod (2^M-1). The consumer performs the indexing.
- done asserts the cycle after the final handshake. err_valid is never high in the same cycle as done.
- All outputs are registered; there is no combinational path from err_ready to err or err_valid.

## Configuration
- **TMEC_CHIEN_FAIL_DETECT_EN defined:** the degree computation, root counter, err_count and fail are implemented as described above.
- **TMEC_CHIEN_FAIL_DETECT_EN undefined:**
  - the degree logic and counter are removed;
  - err_count and fail are tied to 0;
  - done and all other behaviour are unchanged.

## Test plan
All cases use M=4, T=3, S=0, L=15, primitive polynomial x^4+x+1, and err_ready held at 1 unless noted.
- No errors: sigma={0,0,0,1} → 15 flags, all 0; done at cycle 17 after start; err_count=0, fail=0.
- Single error: sigma={0,0,8,1} (sigma_1=α^3) → err=1 only at k=12; err_count=1, fail=0.
- Double error: sigma={0,0xB,0x2,1} (α^7, α) → err=1 at k=10 and k=13 only; err_count=2, fail=0.
- Shortened miss: same sigma as the double-error case with L=11 → err=1 at k=10 only; err_last at k=10; err_count=1, fail=1.
- Backpressure: double-error case with err_ready deasserted at k=5 and k=10 for 3 cycles each → err and k hold stable during the stall; the flag sequence is identical to the unstalled case; done is delayed by 6 cycles.
- Reset at k=7, then start again on the next cycle → all outputs are 0 during reset; the new codeword starts cleanly at k=0 with a correct count; a start pulsed mid-run is ignored.
